// File: rtl/rf_write_back_queue.sv
// Write-back queue feeding a single-ported register file: drains queued results on
// idle read cycles, forwards pending data to operand fetch, and forces a drain when full.
module rf_write_back_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WB_VALID,
  input  logic [ADDR_WIDTH-1:0]   WB_ADDR,
  input  logic [DATA_WIDTH-1:0]   WB_DATA,
  output logic                    WB_READY,
  input  logic                    RD_REQ,
  output logic                    RD_GRANT,
  input  logic [ADDR_WIDTH-1:0]   RD_ADDR1,
  input  logic [ADDR_WIDTH-1:0]   RD_ADDR2,
  output logic                    FWD_HIT1,
  output logic                    FWD_HIT2,
  output logic [DATA_WIDTH-1:0]   FWD_DATA1,
  output logic [DATA_WIDTH-1:0]   FWD_DATA2,
  output logic                    RF_WRITE,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR_W,
  output logic [DATA_WIDTH-1:0]   RF_DATA_W,
  output logic [$clog2(DEPTH):0]  COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_DRAIN,
    ARB_READ,
    ARB_FORCE
  } arb_e;

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [PW:0]           r_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  arb_e                  w_mode;
  logic [PW-1:0]         w_idx;

  assign w_full   = (r_count == FULL_COUNT);
  assign w_empty  = (r_count == '0);
  assign WB_READY = !w_full;
  // Register-0 writes complete the handshake but never occupy a slot.
  assign w_push   = WB_VALID && !w_full && (WB_ADDR != '0);
  assign COUNT    = r_count;

  assign RF_ADDR_W = w_empty ? '0 : r_addr[r_head];
  assign RF_DATA_W = w_empty ? '0 : r_data[r_head];

  always_comb begin
    w_mode = ARB_IDLE;
    if (w_empty)      w_mode = ARB_IDLE;
    else if (!RD_REQ) w_mode = ARB_DRAIN;
    else if (w_full)  w_mode = ARB_FORCE;
    else              w_mode = ARB_READ;
  end

  always_comb begin
    RD_GRANT = 1'b0;
    w_pop    = 1'b0;
    case (w_mode)
      ARB_IDLE:  RD_GRANT = RD_REQ;
      ARB_DRAIN: w_pop    = 1'b1;
      ARB_READ:  RD_GRANT = 1'b1;
      ARB_FORCE: w_pop    = 1'b1;
      default:   RD_GRANT = 1'b0;
    endcase
  end

  assign RF_WRITE = w_pop;

  // Walk oldest to youngest so the last match seen is the newest value.
  always_comb begin
    FWD_HIT1  = 1'b0;
    FWD_HIT2  = 1'b0;
    FWD_DATA1 = '0;
    FWD_DATA2 = '0;
    w_idx     = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((PW+1)'(i) < r_count) begin
        if ((RD_ADDR1 != '0) && (r_addr[w_idx] == RD_ADDR1)) begin
          FWD_HIT1  = 1'b1;
          FWD_DATA1 = r_data[w_idx];
        end
        if ((RD_ADDR2 != '0) && (r_addr[w_idx] == RD_ADDR2)) begin
          FWD_HIT2  = 1'b1;
          FWD_DATA2 = r_data[w_idx];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[r_tail] <= WB_ADDR;
        r_data[r_tail] <= WB_DATA;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_back_queue.sv
// Scoreboard bench for rf_write_back_queue: expected register-file writes are queued
// at issue time and a negedge monitor retires them as RF_WRITE appears.
module tb_rf_write_back_queue;

  logic        CLK;
  logic        RST;
  logic        WB_VALID;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic        WB_READY;
  logic        RD_REQ;
  logic        RD_GRANT;
  logic [4:0]  RD_ADDR1;
  logic [4:0]  RD_ADDR2;
  logic        FWD_HIT1;
  logic        FWD_HIT2;
  logic [31:0] FWD_DATA1;
  logic [31:0] FWD_DATA2;
  logic        RF_WRITE;
  logic [4:0]  RF_ADDR_W;
  logic [31:0] RF_DATA_W;
  logic [2:0]  COUNT;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wbEntry_t;

  wbEntry_t expQ[$];
  int nChecks = 0;
  int nFails  = 0;

  rf_write_back_queue #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST),
    .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .WB_READY(WB_READY),
    .RD_REQ(RD_REQ), .RD_GRANT(RD_GRANT), .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2),
    .FWD_HIT1(FWD_HIT1), .FWD_HIT2(FWD_HIT2), .FWD_DATA1(FWD_DATA1), .FWD_DATA2(FWD_DATA2),
    .RF_WRITE(RF_WRITE), .RF_ADDR_W(RF_ADDR_W), .RF_DATA_W(RF_DATA_W), .COUNT(COUNT)
  );

  // 10 ns clock; inputs change 1 ns after each rising edge, outputs sampled on the falling edge.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] addr, input logic [31:0] data,
                               input logic rdReq, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge CLK);
    #1;
    WB_VALID = valid;
    WB_ADDR  = addr;
    WB_DATA  = data;
    RD_REQ   = rdReq;
    RD_ADDR1 = a1;
    RD_ADDR2 = a2;
  endtask

  task automatic expectWrite(input logic [4:0] addr, input logic [31:0] data);
    wbEntry_t e;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Every register-file write must match the oldest outstanding expected write.
  always @(negedge CLK) begin
    if (RST) begin
      checkOutput("grant_write_exclusive", 32'(RD_GRANT & RF_WRITE), 32'd0);
      if (RF_WRITE) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write_addr", 32'(RF_ADDR_W), 32'd0);
          checkOutput("unexpected_write", 32'd1, 32'd0);
        end else begin
          checkOutput("sb_write_addr", 32'(RF_ADDR_W), 32'(expQ[0].addr));
          checkOutput("sb_write_data", RF_DATA_W, expQ[0].data);
          void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b0; WB_VALID = 1'b0; WB_ADDR = '0; WB_DATA = '0;
    RD_REQ = 1'b0; RD_ADDR1 = '0; RD_ADDR2 = '0;

    // Reset state
    #2;
    checkOutput("rst_count", 32'(COUNT), 32'd0);
    checkOutput("rst_ready", 32'(WB_READY), 32'd1);
    checkOutput("rst_rf_write", 32'(RF_WRITE), 32'd0);
    checkOutput("rst_rf_addr", 32'(RF_ADDR_W), 32'd0);
    checkOutput("rst_rf_data", RF_DATA_W, 32'd0);
    checkOutput("rst_fwd_hit1", 32'(FWD_HIT1), 32'd0);
    checkOutput("rst_fwd_data2", FWD_DATA2, 32'd0);
    checkOutput("rst_grant_noreq", 32'(RD_GRANT), 32'd0);
    RD_REQ = 1'b1;
    #1;
    checkOutput("rst_grant_req", 32'(RD_GRANT), 32'd1);
    RD_REQ = 1'b0;
    @(posedge CLK);
    #3;
    RST = 1'b1;

    // Single push drains the next cycle
    applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 5'd0);
    expectWrite(5'd5, 32'h1234_5678);
    @(negedge CLK);
    checkOutput("t1_push_cycle_count", 32'(COUNT), 32'd0);
    checkOutput("t1_push_cycle_write", 32'(RF_WRITE), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    @(negedge CLK);
    checkOutput("t1_drain_write", 32'(RF_WRITE), 32'd1);
    checkOutput("t1_drain_count", 32'(COUNT), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    @(negedge CLK);
    checkOutput("t1_after_count", 32'(COUNT), 32'd0);
    checkOutput("t1_after_write", 32'(RF_WRITE), 32'd0);

    // Fill with reads held, then a FORCE drain
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h11 * i, 1'b1, 5'd0, 5'd0);
      expectWrite(5'(i), 32'h11 * i);
      @(negedge CLK);
      checkOutput("t2_fill_count", 32'(COUNT), 32'(i - 1));
      checkOutput("t2_fill_grant", 32'(RD_GRANT), 32'd1);
      checkOutput("t2_fill_ready", 32'(WB_READY), 32'd1);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    @(negedge CLK);
    checkOutput("t2_full_count", 32'(COUNT), 32'd4);
    checkOutput("t2_full_ready", 32'(WB_READY), 32'd0);
    checkOutput("t2_force_grant", 32'(RD_GRANT), 32'd0);
    checkOutput("t2_force_write", 32'(RF_WRITE), 32'd1);
    checkOutput("t2_force_addr", 32'(RF_ADDR_W), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    @(negedge CLK);
    checkOutput("t2_post_count", 32'(COUNT), 32'd3);
    checkOutput("t2_post_grant", 32'(RD_GRANT), 32'd1);
    checkOutput("t2_post_write", 32'(RF_WRITE), 32'd0);
    checkOutput("t2_post_ready", 32'(WB_READY), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    @(negedge CLK);
    checkOutput("t2_drained_count", 32'(COUNT), 32'd0);

    // Two writes to r7: newest value forwarded, both drain in order
    applyStimulus(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 5'd0);
    expectWrite(5'd7, 32'hA);
    @(negedge CLK);
    checkOutput("t3_same_cycle_hit", 32'(FWD_HIT1), 32'd0);
    applyStimulus(1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 5'd0);
    expectWrite(5'd7, 32'hB);
    @(negedge CLK);
    checkOutput("t3_first_hit", 32'(FWD_HIT1), 32'd1);
    checkOutput("t3_first_data", FWD_DATA1, 32'hA);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0);
    @(negedge CLK);
    checkOutput("t3_count", 32'(COUNT), 32'd2);
    checkOutput("t3_newest_hit", 32'(FWD_HIT1), 32'd1);
    checkOutput("t3_newest_data", FWD_DATA1, 32'hB);
    checkOutput("t3_miss_hit2", 32'(FWD_HIT2), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    @(negedge CLK);
    checkOutput("t3_drained_count", 32'(COUNT), 32'd0);

    // Register 0: accepted but never queued or forwarded
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 5'd0);
    @(negedge CLK);
    checkOutput("t4_ready", 32'(WB_READY), 32'd1);
    checkOutput("t4_hit2", 32'(FWD_HIT2), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    @(negedge CLK);
    checkOutput("t4_count", 32'(COUNT), 32'd0);
    checkOutput("t4_write", 32'(RF_WRITE), 32'd0);
    checkOutput("t4_hit2_after", 32'(FWD_HIT2), 32'd0);

    // Sustained push+pop at COUNT=2 across pointer wrap
    applyStimulus(1'b1, 5'd10, 32'h1000_0010, 1'b1, 5'd0, 5'd0);
    expectWrite(5'd10, 32'h1000_0010);
    applyStimulus(1'b1, 5'd11, 32'h1000_0011, 1'b1, 5'd0, 5'd0);
    expectWrite(5'd11, 32'h1000_0011);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 5'(12 + k), 32'h2000_0000 + k, 1'b0, 5'd11, 5'd10);
      expectWrite(5'(12 + k), 32'h2000_0000 + k);
      @(negedge CLK);
      checkOutput("t5_steady_count", 32'(COUNT), 32'd2);
      if (k == 0) begin
        checkOutput("t5_head_fwd_hit", 32'(FWD_HIT2), 32'd1);
        checkOutput("t5_head_fwd_data", FWD_DATA2, 32'h1000_0010);
        checkOutput("t5_tail_fwd_data", FWD_DATA1, 32'h1000_0011);
      end
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    @(negedge CLK);
    checkOutput("t5_drained_count", 32'(COUNT), 32'd0);

    // Asynchronous reset with three entries queued: they must never be written
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'(20 + i), 32'h20 + i, 1'b1, 5'd20, 5'd0);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 5'd0);
    #1;
    checkOutput("t6_pre_count", 32'(COUNT), 32'd3);
    checkOutput("t6_pre_fwd", FWD_DATA1, 32'h20);
    #1;
    RST = 1'b0;
    #1;
    checkOutput("t6_rst_count", 32'(COUNT), 32'd0);
    checkOutput("t6_rst_write", 32'(RF_WRITE), 32'd0);
    checkOutput("t6_rst_data", RF_DATA_W, 32'd0);
    checkOutput("t6_rst_fwd", 32'(FWD_HIT1), 32'd0);
    RD_REQ = 1'b0;
    @(posedge CLK);
    #3;
    RST = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd20, 5'd0);
    @(negedge CLK);
    checkOutput("t6_post_count", 32'(COUNT), 32'd0);
    checkOutput("t6_post_data", RF_DATA_W, 32'd0);

    checkOutput("sb_all_retired", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
